// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream port of the UART frame controller: byte, valid, last marker, ready.
interface uart_rx_frame_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer over an 8-bit UART receiver: hunts SOF, buffers LEN payload bytes,
// verifies the additive checksum, then streams the payload out; errors pulse rx_en low.
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'h7E,
  parameter int unsigned TIMEOUT        = 2048,
  parameter int unsigned RECOVER_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  output logic                        o_rx_en,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_rx_err,
  uart_rx_frame_ctrl_if.master        m_if,
  output logic                        o_frame_ok,
  output logic                        o_frame_bad,
  output logic [7:0]                  o_err_count
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RcvLast = RW'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StHunt, StLen, StPayload, StCsum, StDrain, StBad, StRecover
  } state_e;

  state_e        r_state;
  logic          r_rx_en;
  logic [7:0]    r_m_data;
  logic          r_m_valid;
  logic          r_m_last;
  logic          r_frame_ok;
  logic          r_frame_bad;
  logic [7:0]    r_err_count;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_rd;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tmo;
  logic [RW-1:0] r_rcv;
  logic [7:0]    r_buf [MAX_LEN];

  logic          w_len_bad;
  logic          w_idx_last;
  logic [LW-1:0] w_rd_nxt;
  logic          w_rd_last_nxt;
  logic          w_tmo_hit;
  logic          w_buf_we;

  assign w_len_bad     = (i_rx_data == 8'd0) || (32'(i_rx_data) > MAX_LEN);
  assign w_idx_last    = (r_idx == r_len - LW'(1));
  assign w_rd_nxt      = r_rd + LW'(1);
  assign w_rd_last_nxt = (w_rd_nxt == r_len - LW'(1));
  assign w_tmo_hit     = (r_tmo == TmoLast);
  assign w_buf_we      = i_enable && (r_state == StPayload) && i_rx_done && !i_rx_err;

  // Payload storage needs no reset: it is only read after being written in this frame.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx[IW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rx_en     <= 1'b0;
      r_m_data    <= 8'd0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_bad <= 1'b0;
      r_err_count <= 8'd0;
      r_len       <= '0;
      r_idx       <= '0;
      r_rd        <= '0;
      r_sum       <= 8'd0;
      r_tmo       <= '0;
      r_rcv       <= '0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_bad <= 1'b0;
      if (!i_enable) begin
        r_state   <= StIdle;
        r_rx_en   <= 1'b0;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_state <= StHunt;
            r_rx_en <= 1'b1;
          end
          StHunt: begin
            if (i_rx_err) begin
              r_state <= StBad;
            end else if (i_rx_done && (i_rx_data == SOF_BYTE)) begin
              r_state <= StLen;
              r_tmo   <= '0;
            end
          end
          StLen, StPayload, StCsum: begin
            r_tmo <= r_tmo + TW'(1);
            if (i_rx_err) begin
              r_state <= StBad;
            end else if (i_rx_done) begin
              r_tmo <= '0;
              if (r_state == StLen) begin
                if (w_len_bad) begin
                  r_state <= StBad;
                end else begin
                  r_len   <= LW'(i_rx_data);
                  r_idx   <= '0;
                  r_sum   <= 8'd0;
                  r_state <= StPayload;
                end
              end else if (r_state == StPayload) begin
                r_sum <= r_sum + i_rx_data;
                r_idx <= r_idx + LW'(1);
                if (w_idx_last) r_state <= StCsum;
              end else if (i_rx_data == r_sum) begin
                r_frame_ok <= 1'b1;
                r_state    <= StDrain;
              end else begin
                r_state <= StBad;
              end
            end else if (w_tmo_hit) begin
              r_state <= StBad;
            end
          end
          StDrain: begin
            // A byte arriving while draining means the buffer would be overwritten.
            if (i_rx_err || i_rx_done) begin
              r_state   <= StBad;
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
            end else if (r_frame_ok) begin
              r_m_valid <= 1'b1;
              r_m_data  <= r_buf[0];
              r_m_last  <= (r_len == LW'(1));
              r_rd      <= '0;
            end else if (r_m_valid && m_if.m_ready) begin
              if (r_m_last) begin
                r_state   <= StHunt;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
              end else begin
                r_rd     <= w_rd_nxt;
                r_m_data <= r_buf[w_rd_nxt[IW-1:0]];
                r_m_last <= w_rd_last_nxt;
              end
            end
          end
          StBad: begin
            r_frame_bad <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_rx_en <= 1'b0;
            r_rcv   <= '0;
            r_state <= StRecover;
          end
          StRecover: begin
            if (r_rcv == RcvLast) begin
              r_state <= StHunt;
              r_rx_en <= 1'b1;
            end else begin
              r_rcv <= r_rcv + RW'(1);
            end
          end
          default: begin
            r_state <= StIdle;
            r_rx_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx_en      = r_rx_en;
  assign m_if.m_data  = r_m_data;
  assign m_if.m_valid = r_m_valid;
  assign m_if.m_last  = r_m_last;
  assign o_frame_ok   = r_frame_ok;
  assign o_frame_bad  = r_frame_bad;
  assign o_err_count  = r_err_count;

endmodule
